// File: rtl/mem_bus_sequencer_if.sv
// Request/bus bundle between the fetch/data requesters and the sequencer.
// The slave side is the sequencer; the master side drives the requests.
interface mem_bus_sequencer_if;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic       fetch_done;
  logic [7:0] fetch_rdata;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_done;
  logic [7:0] mem_rdata;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       rom_ram;
  logic       addr_data;
  logic       bus_we;
  logic       busy;

  modport slave (
    input  fetch_req, fetch_addr,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  bus_in,
    output fetch_done, fetch_rdata,
    output mem_done, mem_rdata,
    output bus_out, rom_ram, addr_data, bus_we, busy
  );

  modport master (
    output fetch_req, fetch_addr,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output bus_in,
    input  fetch_done, fetch_rdata,
    input  mem_done, mem_rdata,
    input  bus_out, rom_ram, addr_data, bus_we, busy
  );
endinterface

// File: rtl/mem_bus_sequencer.sv
// Shares one multiplexed address/data bus between instruction fetch
// and data memory with alternating arbitration.
module mem_bus_sequencer #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic          clk,
  input logic          reset,
  mem_bus_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    DATA,
    DONE
  } state_t;

  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic HAS_WAIT = (WAIT_CYCLES != 0);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       src_q, src_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       last_q, last_d;
  logic [7:0] frd_q, mrd_q;

  logic       any_req;
  logic       grant_mem;

  logic [7:0] bus_out_c;
  logic       rom_ram_c;
  logic       addr_data_c;
  logic       bus_we_c;
  logic       busy_c;
  logic       fdone_c;
  logic       mdone_c;

  // On a tie the requester not served last wins (last_q: 1 = mem).
  always_comb begin
    any_req   = bus.fetch_req | bus.mem_req;
    grant_mem = bus.mem_req & (~bus.fetch_req | ~last_q);
  end

  // Next-state and request latching.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    src_d   = src_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          src_d   = grant_mem;
          last_d  = grant_mem;
          we_d    = grant_mem & bus.mem_we;
          addr_d  = grant_mem ? bus.mem_addr : bus.fetch_addr;
          wdata_d = grant_mem ? bus.mem_wdata : 8'h00;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (HAS_WAIT) begin
          wait_d  = WLOAD;
          state_d = WAIT;
        end else begin
          state_d = DATA;
        end
      end
      WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = DATA;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      DATA: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus phase and completion outputs decoded from the current state.
  always_comb begin
    bus_out_c   = 8'h00;
    rom_ram_c   = 1'b0;
    addr_data_c = 1'b0;
    bus_we_c    = 1'b0;
    busy_c      = 1'b1;
    fdone_c     = 1'b0;
    mdone_c     = 1'b0;
    unique case (state_q)
      IDLE: busy_c = 1'b0;
      ADDR: begin
        bus_out_c   = addr_q;
        rom_ram_c   = src_q;
        addr_data_c = 1'b1;
      end
      WAIT: begin
        bus_out_c = addr_q;
        rom_ram_c = src_q;
      end
      DATA: begin
        rom_ram_c = src_q;
        if (we_q) begin
          bus_out_c = wdata_q;
          bus_we_c  = 1'b1;
        end
      end
      DONE: begin
        fdone_c = ~src_q;
        mdone_c = src_q;
      end
      default: busy_c = 1'b0;
    endcase
  end

  // State, latches and read-data capture at the end of a read DATA cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
      src_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      last_q  <= 1'b1;
      frd_q   <= 8'h00;
      mrd_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      src_q   <= src_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      if (state_q == DATA && !we_q) begin
        if (src_q) begin
          mrd_q <= bus.bus_in;
        end else begin
          frd_q <= bus.bus_in;
        end
      end
    end
  end

  assign bus.bus_out     = bus_out_c;
  assign bus.rom_ram     = rom_ram_c;
  assign bus.addr_data   = addr_data_c;
  assign bus.bus_we      = bus_we_c;
  assign bus.busy        = busy_c;
  assign bus.fetch_done  = fdone_c;
  assign bus.mem_done    = mdone_c;
  assign bus.fetch_rdata = frd_q;
  assign bus.mem_rdata   = mrd_q;

endmodule
